// File: rtl/demux_1xn_reg.sv
// Registered 1-to-N demultiplexer with per-channel holding slots and valid/ack handshake.
// Optional broadcast write in addressed mode is enabled by defining DEMUX_BCAST_EN.
module demux_1xn_reg #(
    parameter int BITS     = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_BITS = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [BITS-1:0]            in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       mode,
    input  logic [SEL_BITS-1:0]        sel,
    input  logic                       rr_clear,
    input  logic                       bcast,
    output logic [CHANNELS*BITS-1:0]   out_data,
    output logic [CHANNELS-1:0]        out_valid,
    input  logic [CHANNELS-1:0]        out_ack,
    output logic [SEL_BITS-1:0]        ptr,
    output logic                       err
);

    localparam logic [SEL_BITS:0]   NUM_CH  = (SEL_BITS+1)'(CHANNELS);
    localparam logic [SEL_BITS-1:0] LAST_CH = SEL_BITS'(CHANNELS - 1);

    logic [CHANNELS-1:0][BITS-1:0] data_q, data_d;
    logic [CHANNELS-1:0]           valid_q, valid_d;
    logic [SEL_BITS-1:0]           ptr_q, ptr_d;
    logic                          err_q, err_d;

    logic [SEL_BITS-1:0] tgt;
    logic                tgt_in_range;
    logic                tgt_full;
    logic                sel_oor;
    logic                normal_ready;
    logic                accept;

    assign tgt          = mode ? ptr_q : sel;
    assign tgt_in_range = {1'b0, tgt} < NUM_CH;
    assign sel_oor      = {1'b0, sel} >= NUM_CH;

    // Indexed through a loop so an out-of-range target never indexes past valid_q.
    always_comb begin
        tgt_full = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (tgt == SEL_BITS'(k)) tgt_full = valid_q[k];
        end
    end

    assign normal_ready = tgt_in_range & ~tgt_full;

`ifdef DEMUX_BCAST_EN
    logic bcast_act;
    assign bcast_act = ~mode & bcast;
    assign in_ready  = bcast_act ? ~|valid_q : normal_ready;
`else
    logic unused_bcast;
    assign unused_bcast = bcast;
    assign in_ready     = normal_ready;
`endif

    assign accept = in_valid & in_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~out_ack;
        ptr_d   = ptr_q;
        err_d   = err_q;

`ifdef DEMUX_BCAST_EN
        if (accept && bcast_act) begin
            data_d  = {CHANNELS{in_data}};
            valid_d = '1;
        end else
`endif
        if (accept) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                if (tgt == SEL_BITS'(k)) begin
                    data_d[k]  = in_data;
                    valid_d[k] = 1'b1;
                end
            end
        end

        if (accept && mode) begin
            ptr_d = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;
        end
        if (rr_clear) ptr_d = '0;

`ifdef DEMUX_BCAST_EN
        if (in_valid && !mode && !bcast_act && sel_oor) err_d = 1'b1;
`else
        if (in_valid && !mode && sel_oor) err_d = 1'b1;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign ptr       = ptr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_demux_1xn_reg.sv
// Scoreboard bench for demux_1xn_reg: 8-channel main instance plus a 6-channel instance
// for out-of-range select and pointer wrap at a non power-of-two channel count.
module tb_demux_1xn_reg;

    logic        clock;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [2:0]  sel;
    logic        rr_clear;
    logic        bcast;
    logic [63:0] out_data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ack;
    logic [2:0]  ptr;
    logic        err;

    logic        in_valid6;
    logic        in_ready6;
    logic [47:0] out_data6;
    logic [5:0]  out_valid6;
    logic [5:0]  out_ack6;
    logic [2:0]  ptr6;
    logic        err6;

    int errors;
    int checks;
    logic [15:0] exp_q[$];

    demux_1xn_reg #(.BITS(8), .CHANNELS(8), .SEL_BITS(3)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .rr_clear(rr_clear),
        .bcast(bcast), .out_data(out_data), .out_valid(out_valid),
        .out_ack(out_ack), .ptr(ptr), .err(err)
    );

    demux_1xn_reg #(.BITS(8), .CHANNELS(6), .SEL_BITS(3)) dut6 (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid6),
        .in_ready(in_ready6), .mode(mode), .sel(sel), .rr_clear(rr_clear),
        .bcast(bcast), .out_data(out_data6), .out_valid(out_valid6),
        .out_ack(out_ack6), .ptr(ptr6), .err(err6)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] slot(input int k);
        return out_data[k*8 +: 8];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int ch, input logic [7:0] d);
        exp_q.push_back({8'(ch), d});
    endtask

    // Offer one word for one cycle; the caller pushes the expectation when it expects acceptance.
    task automatic send(input bit m, input logic [2:0] s, input logic [7:0] d, input bit b,
                        input bit exp_rdy, input string name);
        mode = m; sel = s; in_data = d; bcast = b; in_valid = 1'b1;
        #1;
        check(name, in_ready, exp_rdy);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        bcast    = 1'b0;
    endtask

    task automatic ack(input int k);
        out_ack = 8'(1) << k;
        tick();
        out_ack = '0;
    endtask

    // Each new word shows up as a 0->1 edge on its out_valid bit.
    task automatic monitor_loop();
        logic [7:0]  prev = '0;
        logic [15:0] e;
        forever begin
            @(negedge clock);
            for (int k = 0; k < 8; k++) begin
                if (out_valid[k] === 1'b1 && prev[k] === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: got word %0h on channel %0d expected none", slot(k), k);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_chan", 64'(k), 64'(e[15:8]));
                        check("sb_data", 64'(slot(k)), 64'(e[7:0]));
                    end
                end
            end
            prev = out_valid;
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b1; in_data = '0; in_valid = 1'b0; mode = 1'b0; sel = '0;
        rr_clear = 1'b0; bcast = 1'b0; out_ack = '0; in_valid6 = 1'b0; out_ack6 = '0;
        fork
            monitor_loop();
        join_none
        tick(); tick();
        reset = 1'b0;

        check("rst_data", out_data, 64'h0);
        check("rst_valid", out_valid, 64'h0);
        check("rst_ptr", ptr, 64'h0);
        check("rst_err", err, 64'h0);

        // Addressed write
        push(5, 8'hA3);
        send(1'b0, 3'd5, 8'hA3, 1'b0, 1'b1, "addr_rdy");
        check("addr_valid", out_valid, 64'h20);
        check("addr_data", out_data, 64'h0000_A300_0000_0000);
        check("addr_err", err, 64'h0);

        // Back-pressure, ack, retry
        send(1'b0, 3'd5, 8'h11, 1'b0, 1'b0, "bp_rdy");
        check("bp_hold", slot(5), 64'hA3);
        check("bp_valid", out_valid, 64'h20);
        ack(3);
        check("ack_empty", out_valid, 64'h20);
        ack(5);
        check("ack_clear", out_valid, 64'h00);
        check("ack_keep", slot(5), 64'hA3);
        push(5, 8'h11);
        send(1'b0, 3'd5, 8'h11, 1'b0, 1'b1, "retry_rdy");
        check("retry_data", slot(5), 64'h11);

        // Ack on one channel while writing another
        out_ack = 8'h20;
        push(2, 8'h77);
        send(1'b0, 3'd2, 8'h77, 1'b0, 1'b1, "ackwr_rdy");
        out_ack = '0;
        check("ackwr_valid", out_valid, 64'h04);
        check("ackwr_keep", slot(5), 64'h11);
        ack(2);

        // Round-robin with wrap
        check("rr_ptr0", ptr, 64'h0);
        for (int i = 0; i < 10; i++) begin
            check("rr_ptr", ptr, 64'(i % 8));
            push(i % 8, 8'(i));
            send(1'b1, 3'd0, 8'(i), 1'b0, 1'b1, "rr_rdy");
            ack(i % 8);
        end
        check("rr_ptr_end", ptr, 64'h2);
        check("rr_slot0", slot(0), 64'h08);
        check("rr_slot1", slot(1), 64'h09);
        rr_clear = 1'b1;
        tick();
        rr_clear = 1'b0;
        check("rr_clear", ptr, 64'h0);

        // rr_clear wins over an advance
        rr_clear = 1'b1;
        push(0, 8'h40);
        send(1'b1, 3'd0, 8'h40, 1'b0, 1'b1, "clr_adv_rdy");
        rr_clear = 1'b0;
        check("clr_adv_ptr", ptr, 64'h0);
        ack(0);

        // Round-robin stall on a full slot
        push(0, 8'h50);
        send(1'b1, 3'd0, 8'h50, 1'b0, 1'b1, "st_rdy0");
        ack(0);
        push(1, 8'h51);
        send(1'b1, 3'd0, 8'h51, 1'b0, 1'b1, "st_rdy1");
        ack(1);
        push(2, 8'h52);
        send(1'b0, 3'd2, 8'h52, 1'b0, 1'b1, "st_rdy2");
        check("mode_keep_ptr", ptr, 64'h2);
        mode = 1'b1; in_data = 8'h60; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("stall_rdy", in_ready, 64'h0);
            check("stall_ptr", ptr, 64'h2);
            tick();
        end
        in_valid = 1'b0;
        check("stall_slot", slot(2), 64'h52);
        ack(2);
        push(2, 8'h60);
        send(1'b1, 3'd0, 8'h60, 1'b0, 1'b1, "unstall_rdy");
        check("unstall_ptr", ptr, 64'h3);
        ack(2);

        // Broadcast request in addressed mode
`ifdef DEMUX_BCAST_EN
        for (int k = 0; k < 8; k++) push(k, 8'h5C);
        send(1'b0, 3'd3, 8'h5C, 1'b1, 1'b1, "bc_rdy");
        check("bc_valid", out_valid, 64'hFF);
        check("bc_data", out_data, 64'h5C5C_5C5C_5C5C_5C5C);
        check("bc_ptr", ptr, 64'h3);
        out_ack = 8'hBF;
        tick();
        out_ack = '0;
        send(1'b0, 3'd3, 8'h5D, 1'b1, 1'b0, "bc_busy_rdy");
        check("bc_err", err, 64'h0);
        ack(6);
`else
        push(3, 8'h5C);
        send(1'b0, 3'd3, 8'h5C, 1'b1, 1'b1, "nobc_rdy");
        check("nobc_valid", out_valid, 64'h08);
        ack(3);
`endif

        // Out-of-range select on the 6-channel instance
        mode = 1'b0; sel = 3'd7; in_valid6 = 1'b1;
        #1;
        check("oor_rdy", in_ready6, 64'h0);
        @(posedge clock); #1;
        in_valid6 = 1'b0;
        check("oor_err", err6, 64'h1);
        check("oor_valid", out_valid6, 64'h0);
        check("oor_data", out_data6, 64'h0);
        sel = 3'd5; in_data = 8'h99; in_valid6 = 1'b1;
        #1;
        check("edge_rdy", in_ready6, 64'h1);
        @(posedge clock); #1;
        in_valid6 = 1'b0;
        check("edge_valid", out_valid6, 64'h20);
        check("edge_data", out_data6[47:40], 64'h99);
        check("err_sticky", err6, 64'h1);
        out_ack6 = 6'h20;
        tick();
        out_ack6 = '0;

        // Pointer wrap at CHANNELS-1 = 5
        mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("wrap_ptr", ptr6, 64'(i % 6));
            in_data = 8'h90 + 8'(i); in_valid6 = 1'b1;
            tick();
            in_valid6 = 1'b0;
            out_ack6 = 6'(1) << (i % 6);
            tick();
            out_ack6 = '0;
        end
        check("wrap_ptr_end", ptr6, 64'h1);
        check("wrap_slot0", out_data6[7:0], 64'h96);

        // Reset during a transfer
        push(1, 8'h31);
        send(1'b0, 3'd1, 8'h31, 1'b0, 1'b1, "pre_rst_rdy");
        mode = 1'b0; sel = 3'd4; in_data = 8'hEE; in_valid = 1'b1; reset = 1'b1;
        tick();
        in_valid = 1'b0; reset = 1'b0;
        check("mid_rst_data", out_data, 64'h0);
        check("mid_rst_valid", out_valid, 64'h0);
        check("mid_rst_ptr", ptr, 64'h0);
        check("mid_rst_err6", err6, 64'h0);
        check("mid_rst_ptr6", ptr6, 64'h0);
        check("mid_rst_data6", out_data6, 64'h0);

        tick(); tick();
        check("sb_drained", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
